// File: rtl/flash_decoder_if.sv
// flash_decoder_if: flash line (in) toward the decoder; count/valid/err back from it
interface flash_decoder_if #(parameter int CWIDTH = 4);
   logic in;
   logic [CWIDTH-1:0] count;
   logic valid;
   logic err;
   modport master (output in, input count, valid, err);
   modport slave (input in, output count, valid, err);
endinterface

// File: rtl/flash_decoder.sv
// flash_decoder: decodes an on/off flash train into a flash count; ports clk, rst (async active-low), f.in -> f.count/f.valid/f.err
module flash_decoder #(
   parameter int TWIDTH = 16,
   parameter int CWIDTH = 4,
   parameter int MIN_ON = 4,
   parameter int MAX_ON = 1000,
   parameter int GAP    = 2000
) (
   input logic clk,
   input logic rst,
   flash_decoder_if.slave f
);
   typedef enum logic [1:0] {IDLE, ON, SPACE, HOLD} state_t;
   state_t state, state_n;
   logic [1:0] sync;
   logic s;
   logic [TWIDTH-1:0] timer, timer_n;
   logic [CWIDTH-1:0] flashes, flashes_n, count_q, count_n;
   logic valid_q, valid_n, err_q, err_n;
   assign s = sync[1];
   assign f.count = count_q;
   assign f.valid = valid_q;
   assign f.err = err_q;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync <= '0;
         state <= IDLE;
         timer <= '0;
         flashes <= '0;
         count_q <= '0;
         valid_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         sync <= {sync[0], f.in};
         state <= state_n;
         timer <= timer_n;
         flashes <= flashes_n;
         count_q <= count_n;
         valid_q <= valid_n;
         err_q <= err_n;
      end
   end
   always_comb begin
      state_n = state;
      timer_n = timer;
      flashes_n = flashes;
      count_n = count_q;
      valid_n = 1'b0;
      err_n = 1'b0;
      unique case (state)
         IDLE: if (s) begin
            state_n = ON;
            timer_n = TWIDTH'(1);
            flashes_n = '0;
         end
         ON: if (s) begin
            if (timer == TWIDTH'(MAX_ON)) begin
               err_n = 1'b1;
               state_n = HOLD;
            end else timer_n = timer + TWIDTH'(1);
         end else if (timer < TWIDTH'(MIN_ON)) begin
            err_n = 1'b1;
            state_n = IDLE;
         end else begin
            flashes_n = (&flashes) ? flashes : flashes + CWIDTH'(1);
            state_n = SPACE;
            timer_n = TWIDTH'(1);
         end
         SPACE: if (s) begin
            state_n = ON;
            timer_n = TWIDTH'(1);
         end else if (timer == TWIDTH'(GAP - 1)) begin
            count_n = flashes;
            valid_n = 1'b1;
            state_n = IDLE;
         end else timer_n = timer + TWIDTH'(1);
         HOLD: state_n = s ? HOLD : IDLE;
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_flash_decoder.sv
// tb_flash_decoder: table-driven and randomized check of flash_decoder against a run-length model
module tb_flash_decoder;
   localparam int MIN_ON = 2;
   localparam int MAX_ON = 8;
   localparam int GAP = 10;
   localparam int CW = 3;
   localparam int SAT = 7;
   typedef bit bq_t[$];
   typedef struct {
      int nfl;
      int hi;
      int lo;
      int exp_count;
      int exp_valids;
      int exp_errs;
   } vec_t;
   logic clk = 1'b0;
   logic rst = 1'b0;
   flash_decoder_if #(.CWIDTH(CW)) fi();
   flash_decoder #(.TWIDTH(16), .CWIDTH(CW), .MIN_ON(MIN_ON), .MAX_ON(MAX_ON), .GAP(GAP)) dut (
      .clk(clk),
      .rst(rst),
      .f(fi)
   );
   always #5 clk = ~clk;
   int compared = 0;
   int mismatched = 0;
   int m_count = 0;
   int n_valid = 0;
   int n_err = 0;
   vec_t tbl[10];
   task automatic chk(input string name, input int act, input int req);
      compared++;
      if (act != req) begin
         mismatched++;
         $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
      end
   endtask
   // Model: walk the sample stream run by run, placing events at the sample index that triggers them.
   task automatic run_samples(input bq_t smp);
      int n;
      int ev_v[];
      int ev_e[];
      int ev_c[];
      int i;
      int st;
      int len;
      int fl;
      bit l;
      bit inseq;
      n = smp.size();
      ev_v = new[n];
      ev_e = new[n];
      ev_c = new[n];
      i = 0;
      fl = 0;
      inseq = 1'b0;
      while (i < n) begin
         st = i;
         l = smp[i];
         while (i < n && smp[i] == l) i++;
         len = i - st;
         if (l) begin
            if (len > MAX_ON) begin
               ev_e[st + MAX_ON] = 1;
               inseq = 1'b0;
            end else if (len < MIN_ON) begin
               if (st + len < n) ev_e[st + len] = 1;
               inseq = 1'b0;
            end else begin
               if (!inseq) fl = 0;
               inseq = 1'b1;
               fl = (fl < SAT) ? fl + 1 : SAT;
            end
         end else if (inseq && len >= GAP) begin
            ev_v[st + GAP - 1] = 1;
            ev_c[st + GAP - 1] = fl;
            inseq = 1'b0;
         end
      end
      n_valid = 0;
      n_err = 0;
      for (int j = 0; j < n + 3; j++) begin
         @(posedge clk);
         #1;
         fi.in = (j < n) ? smp[j] : 1'b0;
         if (j >= 3) begin
            if (ev_v[j - 3] != 0) m_count = ev_c[j - 3];
            chk("valid", int'(fi.valid), ev_v[j - 3]);
            chk("err", int'(fi.err), ev_e[j - 3]);
            chk("count", int'(fi.count), m_count);
            chk("valid_and_err", int'(fi.valid & fi.err), 0);
            n_valid += int'(fi.valid);
            n_err += int'(fi.err);
         end
      end
   endtask
   task automatic train(input int nfl, input int hi, input int lo);
      bq_t q;
      for (int k = 0; k < nfl; k++) begin
         repeat (hi) q.push_back(1'b1);
         repeat (lo) q.push_back(1'b0);
      end
      repeat (GAP + 6) q.push_back(1'b0);
      run_samples(q);
   endtask
   initial begin
      bq_t q;
      tbl[0] = '{3, 4, 4, 3, 1, 0};
      tbl[1] = '{1, 1, 4, 3, 0, 1};
      tbl[2] = '{1, 2, 4, 1, 1, 0};
      tbl[3] = '{1, 12, 4, 1, 0, 1};
      tbl[4] = '{2, 4, 4, 2, 1, 0};
      tbl[5] = '{9, 3, 3, 7, 1, 0};
      tbl[6] = '{1, 8, 4, 1, 1, 0};
      tbl[7] = '{1, 9, 4, 1, 0, 1};
      tbl[8] = '{2, 3, 9, 2, 1, 0};
      tbl[9] = '{2, 3, 10, 1, 2, 0};
      fi.in = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         fi.in = i[0];
         chk("rst_count", int'(fi.count), 0);
         chk("rst_valid", int'(fi.valid), 0);
         chk("rst_err", int'(fi.err), 0);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      fi.in = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk);
         #1;
         chk("idle_count", int'(fi.count), 0);
         chk("idle_valid", int'(fi.valid), 0);
         chk("idle_err", int'(fi.err), 0);
      end
      for (int r = 0; r < 10; r++) begin
         train(tbl[r].nfl, tbl[r].hi, tbl[r].lo);
         chk("row_count", int'(fi.count), tbl[r].exp_count);
         chk("row_valids", n_valid, tbl[r].exp_valids);
         chk("row_errs", n_err, tbl[r].exp_errs);
      end
      for (int k = 0; k < 2; k++) begin
         repeat (4) q.push_back(1'b1);
         repeat (4) q.push_back(1'b0);
      end
      repeat (5) q.push_back(1'b1);
      run_samples(q);
      rst = 1'b0;
      fi.in = 1'b0;
      #1;
      chk("midrst_count", int'(fi.count), 0);
      chk("midrst_valid", int'(fi.valid), 0);
      chk("midrst_err", int'(fi.err), 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      m_count = 0;
      q.delete();
      repeat (GAP + 6) q.push_back(1'b0);
      run_samples(q);
      chk("aborted_valids", n_valid, 0);
      train(4, 4, 4);
      chk("after_rst_count", int'(fi.count), 4);
      chk("after_rst_valids", n_valid, 1);
      for (int t = 0; t < 25; t++) begin
         int nfl;
         q.delete();
         nfl = int'($urandom_range(1, 10));
         for (int k = 0; k < nfl; k++) begin
            repeat ($urandom_range(1, 11)) q.push_back(1'b1);
            repeat ($urandom_range(1, 11)) q.push_back(1'b0);
         end
         repeat (GAP + 6) q.push_back(1'b0);
         run_samples(q);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
